seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_if.sv | 35 +++
 rtl/seg_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Signal bundle between a register/status source and the 7-segment scan
// driver. The source (master) presents display data and scan controls; the
// driver (slave) returns the registered pin-level segment/anode outputs.
//
// load/mode/din form a one-way strobe with no back-pressure. Every clk where
// load is high is a transfer: mode=0 copies the whole frame, mode=1 offers
// one history word. The driver always accepts, so there is no ready signal.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 3
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    clk_en;
    logic                    load;
    logic                    mode;
    logic [4*NUM_DIGITS-1:0] din;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [BRIGHT_W-1:0]     bright;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   seg_en;
    logic [IDX_W-1:0]        scan_idx;

    modport master (
        output clk_en, load, mode, din, dp_in, blank_lz, bright,
        input  seg, dp, seg_en, scan_idx
    );

    modport slave (
        input  clk_en, load, mode, din, dp_in, blank_lz, bright,
        output seg, dp, seg_en, scan_idx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver. Holds a hex display buffer loaded either
// as a whole frame or as a shifting history of words, scans one digit per
// slot, applies leading-zero blanking and PWM brightness, and drives
// registered segment/dp/anode pins in a configurable polarity.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int WORD_DIGITS    = 4,
    parameter int SCAN_CYC       = 50000,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input logic     clk,
    input logic     rst,
    seg_scan_if.slave bus
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int BUF_W  = 4 * NUM_DIGITS;
    localparam int HIST_W = 4 * WORD_DIGITS;

    // XOR masks converting internal active-high values to pin polarity;
    // they are also the "everything off" pin levels.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      scan_idx_q;
    logic [BUF_W-1:0]      buf_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] seg_en_q;

    logic [HIST_W-1:0]     hist_word;
    logic [BUF_W-1:0]      hist_shift;
    logic [NUM_DIGITS:0]   zero_from;
    logic [3:0]            cur_nib;
    logic                  cur_zero;
    logic                  cur_dp;
    logic                  blank;
    logic [6:0]            lit;
    logic [31:0]           on_ticks;
    logic                  slot_on;
    logic [NUM_DIGITS-1:0] onehot;

    // Standard hex font, {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    assign hist_word  = bus.din[HIST_W-1:0];
    assign hist_shift = (buf_q << HIST_W) | BUF_W'(hist_word);

    // Slot counter advances on clk_en; each wrap moves the scan to the next digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt   <= '0;
            scan_idx_q <= '0;
        end else if (bus.clk_en) begin
            if (slot_cnt == CNT_W'(SCAN_CYC - 1)) begin
                slot_cnt   <= '0;
                scan_idx_q <= (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Display buffer: whole-frame copy, or history shift only on a changed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (bus.load) begin
            if (!bus.mode) begin
                buf_q <= bus.din;
            end else if (hist_word != buf_q[HIST_W-1:0]) begin
                buf_q <= hist_shift;
            end
        end
    end

    // Select the current digit, resolve blanking and the PWM on-window.
    always_comb begin
        zero_from             = '1;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (buf_q[4*i +: 4] == 4'h0);
        end
        cur_nib  = 4'h0;
        cur_zero = 1'b0;
        cur_dp   = 1'b0;
        onehot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_nib   = buf_q[4*i +: 4];
                cur_zero  = zero_from[i];
                cur_dp    = bus.dp_in[i];
                onehot[i] = 1'b1;
            end
        end
        blank    = bus.blank_lz && (scan_idx_q != '0) && cur_zero;
        lit      = blank ? 7'h00 : hex_font(cur_nib);
        on_ticks = ((32'(bus.bright) + 32'd1) * 32'(SCAN_CYC)) >> BRIGHT_W;
        slot_on  = (32'(slot_cnt) < on_ticks);
    end

    // Registered pin outputs in the configured polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            seg_en_q <= EN_OFF;
        end else begin
            seg_q    <= lit ^ SEG_OFF;
            dp_q     <= cur_dp ^ DP_OFF;
            seg_en_q <= (slot_on ? onehot : '0) ^ EN_OFF;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.seg_en   = seg_en_q;
    assign bus.scan_idx = scan_idx_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver in the 8-digit, 4-tick-slot, 2-bit brightness,
// active-low configuration. A behavioural model tracks the number of scan
// ticks and the display contents and predicts every registered output.
module tb_seg_scan_driver;
    localparam int ND = 8;
    localparam int WD = 4;
    localparam int SC = 4;
    localparam int BW = 2;
    localparam int XW = 7 + 1 + ND + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS(ND), .WORD_DIGITS(WD), .SCAN_CYC(SC), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int unsigned m_ticks;
    logic [31:0] m_buf;
    logic [XW-1:0] exp_q[$];

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Pin values expected one clk after a state with t_pre elapsed ticks.
    function automatic logic [XW-1:0] expect_out(input int unsigned t_pre, input int unsigned t_post,
                                                 input logic [31:0] b, input logic [ND-1:0] dpi,
                                                 input logic blz, input logic [BW-1:0] br);
        int slot;
        int idx;
        int on;
        logic [31:0] upper;
        logic [6:0] lit;
        logic [ND-1:0] en;
        logic [ND-1:0] one;
        slot  = int'(t_pre % SC);
        idx   = int'((t_pre / SC) % ND);
        on    = ((int'(br) + 1) * SC) >> BW;
        upper = b >> (4 * idx);
        lit   = (blz && idx > 0 && upper == 32'd0) ? 7'h00 : font[upper[3:0]];
        one   = 1;
        en    = (slot < on) ? ~(one << idx) : '1;
        return {~lit, ~dpi[idx], en, 3'((t_post / SC) % ND)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic ce, input logic ld, input logic md, input logic [31:0] d,
                        input logic [ND-1:0] dpi, input logic blz, input logic [BW-1:0] br);
        int unsigned t_post;
        logic [XW-1:0] want;
        bus.clk_en   = ce;
        bus.load     = ld;
        bus.mode     = md;
        bus.din      = d;
        bus.dp_in    = dpi;
        bus.blank_lz = blz;
        bus.bright   = br;
        t_post = m_ticks + (ce ? 1 : 0);
        exp_q.push_back(expect_out(m_ticks, t_post, m_buf, dpi, blz, br));
        @(posedge clk);
        m_ticks = t_post;
        if (ld) begin
            if (!md) m_buf = d;
            else if (d[15:0] != m_buf[15:0]) m_buf = {m_buf[15:0], d[15:0]};
        end
        #1;
        want = exp_q.pop_front();
        check("seg",      32'(bus.seg),      32'(want[XW-1 -: 7]));
        check("dp",       32'(bus.dp),       32'(want[ND+3]));
        check("seg_en",   32'(bus.seg_en),   32'(want[ND+2:3]));
        check("scan_idx", 32'(bus.scan_idx), 32'(want[2:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},    32'(bus.seg),      32'h7F);
        check({tag, "_dp"},     32'(bus.dp),       32'h1);
        check({tag, "_seg_en"}, 32'(bus.seg_en),   32'hFF);
        check({tag, "_idx"},    32'(bus.scan_idx), 32'h0);
    endtask

    task automatic scan(input int n, input logic [ND-1:0] dpi, input logic blz, input logic [BW-1:0] br);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, dpi, blz, br);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        bit reached;
        bus.clk_en = 1'b1; bus.load = 1'b0; bus.mode = 1'b0; bus.din = '0;
        bus.dp_in = '0; bus.blank_lz = 1'b0; bus.bright = '1;
        m_ticks = 0;
        m_buf   = '0;

        #1 rst = 1'b1;
        #2 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por_hold");
        #2 rst = 1'b0;

        // Idle scan after reset: walking anode, digit "0" everywhere.
        scan(34, 8'h00, 1'b0, 2'd3);

        // Direct frame with leading-zero blanking; dp on digit 7 only.
        step(1'b1, 1'b1, 1'b0, 32'h0123ABCD, 8'h80, 1'b1, 2'd3);
        scan(33, 8'h80, 1'b1, 2'd3);

        // History loads: repeat ignored, then oldest word drops out.
        step(1'b1, 1'b1, 1'b1, 32'h0000_1234, 8'h00, 1'b0, 2'd3);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_1234, 8'h00, 1'b0, 2'd3);
        step(1'b1, 1'b1, 1'b1, 32'h0000_5678, 8'h00, 1'b0, 2'd3);
        scan(33, 8'h00, 1'b0, 2'd3);
        step(1'b1, 1'b1, 1'b1, 32'h0000_9ABC, 8'h00, 1'b0, 2'd3);
        scan(33, 8'h00, 1'b0, 2'd3);

        // Brightness sweep and half-rate clk_en.
        for (int b = 0; b < 4; b++) scan(16, 8'h00, 1'b0, 2'(b));
        for (int i = 0; i < 40; i++) step(1'(i % 2), 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 2'd3);

        // Asynchronous reset in the middle of digit 5's slot.
        reached = (((m_ticks / SC) % ND) == 5) && ((m_ticks % SC) == 1);
        for (int i = 0; i < 64 && !reached; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 2'd3);
            reached = (((m_ticks / SC) % ND) == 5) && ((m_ticks % SC) == 1);
        end
        check("reach_digit5", 32'(reached), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        m_ticks = 0;
        m_buf   = '0;
        exp_q.delete();
        #2 rst = 1'b0;
        scan(12, 8'h00, 1'b0, 2'd3);

        // All-zero frame, blanking on, dp requested on digit 2.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0000, 8'h04, 1'b1, 2'd3);
        scan(33, 8'h04, 1'b1, 2'd3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            d = d & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 8)));
            if ($urandom_range(0, 2) == 0) d[15:0] = m_buf[15:0];
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), d, 8'($urandom), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
